// File: rtl/triangle_pkg.sv
// Shared types and default sizing for the triangle wave generator.
package triangle_pkg;

  localparam int unsigned TRI_WIDTH    = 8;
  localparam int unsigned TRI_TICK_DIV = 256;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    PEAK_HOLD,
    TROUGH_HOLD
  } tri_state_t;

endpackage

// File: rtl/pwm_compare.sv
// Free-running PWM counter compared against a duty code; registered output.
module pwm_compare
  import triangle_pkg::*;
#(
  parameter int unsigned WIDTH = TRI_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             gate,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out
);

  logic [WIDTH-1:0] pwm_cnt_q;
  logic             pwm_q;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pwm_q     <= gate && (pwm_cnt_q < duty);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/triangle_wave_gen.sv
// Prescaled up/down triangle code generator driving an R2R bus and a PWM comparator.
// Define TRIANGLE_PEAK_HOLD_EN to hold one extra tick at the peak and at the trough.
module triangle_wave_gen
  import triangle_pkg::*;
#(
  parameter int unsigned WIDTH    = TRI_WIDTH,
  parameter int unsigned TICK_DIV = TRI_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             triangle_en,
  input  logic             r2r_enable,
  input  logic             pwm_enable,
  output logic [WIDTH-1:0] r2r_out,
  output logic             pwm_out,
  output logic [WIDTH-1:0] wave_value,
  output logic             dir_up,
  output logic             period_done
);

  localparam int unsigned      TickW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] WaveMax   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] WaveOne   = WIDTH'(1);
  localparam logic [WIDTH-1:0] WaveMaxM1 = WaveMax - WaveOne;

  tri_state_t       state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             done_q, done_d;
  logic             tick;

  // Prescaler starts from zero on entry to RAMP_UP so the first step lands TICK_DIV later.
  assign tick = triangle_en && (state_q != IDLE) && (tick_cnt_q == TickLast);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (!triangle_en || (state_q == IDLE) || tick) begin
      tick_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    done_d  = 1'b0;
    if (!triangle_en) begin
      state_d = IDLE;
      wave_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (tick) begin
            if (wave_q == WaveMaxM1) begin
              wave_d = WaveMax;
`ifdef TRIANGLE_PEAK_HOLD_EN
              state_d = PEAK_HOLD;
`else
              state_d = RAMP_DOWN;
`endif
            end else begin
              wave_d = wave_q + WaveOne;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (wave_q == WaveOne) begin
              wave_d = '0;
              done_d = 1'b1;
`ifdef TRIANGLE_PEAK_HOLD_EN
              state_d = TROUGH_HOLD;
`else
              state_d = RAMP_UP;
`endif
            end else begin
              wave_d = wave_q - WaveOne;
            end
          end
        end
`ifdef TRIANGLE_PEAK_HOLD_EN
        PEAK_HOLD: begin
          if (tick) state_d = RAMP_DOWN;
        end
        TROUGH_HOLD: begin
          if (tick) state_d = RAMP_UP;
        end
`endif
        default: begin
          state_d = IDLE;
          wave_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      wave_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wave_q     <= wave_d;
      done_q     <= done_d;
    end
  end

  assign wave_value  = wave_q;
  assign dir_up      = (state_q == RAMP_UP);
  assign period_done = done_q;
  assign r2r_out     = r2r_enable ? wave_q : '0;

  pwm_compare #(
    .WIDTH(WIDTH)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .enable (triangle_en),
    .gate   (pwm_enable),
    .duty   (wave_q),
    .pwm_out(pwm_out)
  );

endmodule
